// File: rtl/i2c_reg_access_seq_if.sv
// Host request / byte-controller command bundle for the I2C register-access sequencer.
// slave = the sequencer itself, master = the host plus byte-controller side that drives it.
interface i2c_reg_access_seq_if;
  logic        req;
  logic        we;
  logic [6:0]  dev_addr;
  logic [15:0] reg_addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [7:0]  rdata;
  logic        bc_start;
  logic        bc_stop;
  logic        bc_read;
  logic        bc_write;
  logic        bc_ack_in;
  logic [7:0]  bc_din;
  logic        bc_cmd_ack;
  logic        bc_ack_out;
  logic [7:0]  bc_dout;
  logic        bc_al;

  modport slave (
    input  req, we, dev_addr, reg_addr, wdata,
    input  bc_cmd_ack, bc_ack_out, bc_dout, bc_al,
    output busy, done, status, rdata,
    output bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
  );

  modport master (
    output req, we, dev_addr, reg_addr, wdata,
    output bc_cmd_ack, bc_ack_out, bc_dout, bc_al,
    input  busy, done, status, rdata,
    input  bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
  );
endinterface

// File: rtl/i2c_reg_access_seq.sv
// Turns one register write/read request into the START/addr/data/STOP byte-command
// sequence of the I2C byte controller, with NACK, arbitration-loss and timeout aborts.
module i2c_reg_access_seq #(
  parameter int unsigned REG_ADDR_BYTES = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 nReset,
  i2c_reg_access_seq_if.slave  io_bus
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_NACK = 2'd1;
  localparam logic [1:0] ST_AL   = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_DEVW, S_RA_HI, S_RA_LO, S_WDAT, S_DEVR, S_RDAT, S_STOP, S_FIN
  } state_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
  } cmd_t;

  localparam cmd_t CMD_NONE = '0;

  function automatic cmd_t wr_cmd(input logic start, input logic stop, input logic [7:0] din);
    cmd_t c;
    c       = CMD_NONE;
    c.start = start;
    c.stop  = stop;
    c.write = 1'b1;
    c.din   = din;
    return c;
  endfunction

  state_t            r_state,      w_state;
  cmd_t              r_cmd,        w_cmd;
  logic              r_busy,       w_busy;
  logic              r_done,       w_done;
  logic [1:0]        r_status,     w_status;
  logic [1:0]        r_fin_status, w_fin_status;
  logic [7:0]        r_rdata,      w_rdata;
  logic              r_we,         w_we;
  logic [6:0]        r_dev_addr,   w_dev_addr;
  logic [15:0]       r_reg_addr,   w_reg_addr;
  logic [7:0]        r_wdata,      w_wdata;
  logic [CNT_W-1:0]  r_cnt,        w_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_tmo;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_tmo     = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Next-state / next-output logic; precedence in command states is bc_al > bc_cmd_ack > timeout.
  always_comb begin
    w_state      = r_state;
    w_cmd        = r_cmd;
    w_busy       = r_busy;
    w_done       = 1'b0;
    w_status     = r_status;
    w_fin_status = r_fin_status;
    w_rdata      = r_rdata;
    w_we         = r_we;
    w_dev_addr   = r_dev_addr;
    w_reg_addr   = r_reg_addr;
    w_wdata      = r_wdata;
    w_cnt        = w_cnt_inc;

    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (io_bus.req) begin
          w_we       = io_bus.we;
          w_dev_addr = io_bus.dev_addr;
          w_reg_addr = io_bus.reg_addr;
          w_wdata    = io_bus.wdata;
          w_busy     = 1'b1;
          w_cmd      = wr_cmd(1'b1, 1'b0, {io_bus.dev_addr, 1'b0});
          w_state    = S_DEVW;
        end
      end
      S_FIN: begin
        w_cnt    = '0;
        w_cmd    = CMD_NONE;
        w_done   = 1'b1;
        w_busy   = 1'b0;
        w_status = r_fin_status;
        w_state  = S_IDLE;
      end
      default: begin
        if (io_bus.bc_al) begin
          w_cmd        = CMD_NONE;
          w_fin_status = ST_AL;
          w_state      = S_FIN;
        end else if (io_bus.bc_cmd_ack) begin
          w_cnt = '0;
          if (r_cmd.write && io_bus.bc_ack_out) begin
            // Slave refused a byte: release the bus with a bare STOP.
            w_cmd        = CMD_NONE;
            w_cmd.stop   = 1'b1;
            w_fin_status = ST_NACK;
            w_state      = S_STOP;
          end else begin
            case (r_state)
              S_DEVW: begin
                if (REG_ADDR_BYTES == 2) begin
                  w_cmd   = wr_cmd(1'b0, 1'b0, r_reg_addr[15:8]);
                  w_state = S_RA_HI;
                end else begin
                  w_cmd   = wr_cmd(1'b0, 1'b0, r_reg_addr[7:0]);
                  w_state = S_RA_LO;
                end
              end
              S_RA_HI: begin
                w_cmd   = wr_cmd(1'b0, 1'b0, r_reg_addr[7:0]);
                w_state = S_RA_LO;
              end
              S_RA_LO: begin
                if (r_we) begin
                  w_cmd   = wr_cmd(1'b0, 1'b1, r_wdata);
                  w_state = S_WDAT;
                end else begin
                  w_cmd   = wr_cmd(1'b1, 1'b0, {r_dev_addr, 1'b1});
                  w_state = S_DEVR;
                end
              end
              S_DEVR: begin
                w_cmd        = CMD_NONE;
                w_cmd.read   = 1'b1;
                w_cmd.ack_in = 1'b1;
                w_cmd.stop   = 1'b1;
                w_state      = S_RDAT;
              end
              S_RDAT: begin
                w_rdata      = io_bus.bc_dout;
                w_fin_status = ST_OK;
                w_cmd        = CMD_NONE;
                w_state      = S_FIN;
              end
              S_WDAT: begin
                w_fin_status = ST_OK;
                w_cmd        = CMD_NONE;
                w_state      = S_FIN;
              end
              default: begin
                w_cmd   = CMD_NONE;
                w_state = S_FIN;
              end
            endcase
          end
        end else if (w_tmo) begin
          w_cmd        = CMD_NONE;
          w_fin_status = ST_TMO;
          w_state      = S_FIN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state      <= S_IDLE;
      r_cmd        <= CMD_NONE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_status     <= 2'd0;
      r_fin_status <= 2'd0;
      r_rdata      <= 8'd0;
      r_we         <= 1'b0;
      r_dev_addr   <= 7'd0;
      r_reg_addr   <= 16'd0;
      r_wdata      <= 8'd0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state;
      r_cmd        <= w_cmd;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_status     <= w_status;
      r_fin_status <= w_fin_status;
      r_rdata      <= w_rdata;
      r_we         <= w_we;
      r_dev_addr   <= w_dev_addr;
      r_reg_addr   <= w_reg_addr;
      r_wdata      <= w_wdata;
      r_cnt        <= w_cnt;
    end
  end

  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.status    = r_status;
  assign io_bus.rdata     = r_rdata;
  assign io_bus.bc_start  = r_cmd.start;
  assign io_bus.bc_stop   = r_cmd.stop;
  assign io_bus.bc_read   = r_cmd.read;
  assign io_bus.bc_write  = r_cmd.write;
  assign io_bus.bc_ack_in = r_cmd.ack_in;
  assign io_bus.bc_din    = r_cmd.din;
endmodule
